// File: rtl/demux_1to4_buffered_pkg.sv
// Shared constants and the select decoder for the buffered 1-to-4 demultiplexer.
package demux_1to4_buffered_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   localparam logic [SEL_W-1:0] CH0 = 2'd0;
   localparam logic [SEL_W-1:0] CH1 = 2'd1;
   localparam logic [SEL_W-1:0] CH2 = 2'd2;
   localparam logic [SEL_W-1:0] CH3 = 2'd3;

   function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      case (sel)
         CH0:     oh = 4'b0001;
         CH1:     oh = 4'b0010;
         CH2:     oh = 4'b0100;
         CH3:     oh = 4'b1000;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with full flag; load wins over drain so a word can
// be replaced in the same cycle it is consumed. Latency 1 cycle, no internal stall.
module demux_slot #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         drain,
   input  logic [N-1:0] d,
   output logic         full,
   output logic [N-1:0] q
);

   logic         full_q;
   logic         full_d;
   logic [N-1:0] data_q;
   logic [N-1:0] data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (load) begin
         full_d = 1'b1;
         data_d = d;
      end else if (drain) begin
         // Word stays in data_q after drain; consumers ignore it once full drops.
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign q    = data_q;

endmodule

// File: rtl/demux_1to4_buffered.sv
// Registered 1-to-4 demux: steers in_data to channel in_sel, one-cycle latency.
// Backpressure: in_ready drops only when the selected channel is full and not draining.
module demux_1to4_buffered
   import demux_1to4_buffered_pkg::*;
#(
   parameter int N    = 4,
   parameter int CNTW = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        in_data,
   input  logic [SEL_W-1:0]    in_sel,
   output logic [NUM_CH-1:0]   out_valid,
   input  logic [NUM_CH-1:0]   out_ready,
   output logic [NUM_CH*N-1:0] out_data,
   output logic [CNTW-1:0]     accept_count
);

   logic [NUM_CH-1:0] full_w;
   logic [NUM_CH-1:0] drain_w;
   logic [NUM_CH-1:0] load_w;
   logic              accept_w;

   logic [CNTW-1:0]   accept_count_q;
   logic [CNTW-1:0]   accept_count_d;

   assign in_ready = !full_w[in_sel] || out_ready[in_sel];
   assign accept_w = in_valid && in_ready;
   assign load_w   = accept_w ? sel_onehot(in_sel) : '0;
   assign drain_w  = full_w & out_ready;

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_slot
         demux_slot #(
            .N (N)
         ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load_w[k]),
            .drain (drain_w[k]),
            .d     (in_data),
            .full  (full_w[k]),
            .q     (out_data[k*N +: N])
         );
      end
   endgenerate

   always_comb begin
      accept_count_d = accept_count_q;
      if (accept_w) begin
         accept_count_d = accept_count_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         accept_count_q <= '0;
      end else begin
         accept_count_q <= accept_count_d;
      end
   end

   assign out_valid    = full_w;
   assign accept_count = accept_count_q;

endmodule

// File: tb/tb_demux_1to4_buffered.sv
// Randomised and directed bench for demux_1to4_buffered against a per-channel queue model.
module tb_demux_1to4_buffered;

   localparam int N    = 4;
   localparam int CNTW = 8;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_data;
   logic [1:0]      in_sel;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready;
   logic [4*N-1:0]  out_data;
   logic [CNTW-1:0] accept_count;

   demux_1to4_buffered #(
      .N    (N),
      .CNTW (CNTW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_sel       (in_sel),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .accept_count (accept_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: each channel holds at most one word; a count of accepts.
   bit         m_full [4];
   logic [N-1:0] m_data [4];
   int         m_count;
   bit         m_known;

   logic       last_rdy;
   bit         last_acc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [3:0]     ev;
      logic [4*N-1:0] ed;
      for (int k = 0; k < 4; k++) begin
         ev[k] = m_full[k];
         ed[k*N +: N] = m_data[k];
      end
      check_eq("out_valid", {28'd0, out_valid}, {28'd0, ev});
      check_eq("out_data", {16'd0, out_data}, {16'd0, ed});
      check_eq("accept_count", {24'd0, accept_count}, m_count % (1 << CNTW));
   endtask

   // Called at a negedge: drives one cycle, checks in_ready, advances model and DUT.
   task automatic step(input logic v, input logic [N-1:0] d, input logic [1:0] s,
                       input logic [3:0] r, input logic rst);
      bit exp_rdy;
      in_valid  = v;
      in_data   = d;
      in_sel    = s;
      out_ready = r;
      reset     = rst;
      #1;
      exp_rdy  = !m_full[s] || r[s];
      last_rdy = in_ready;
      if (m_known) check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      last_acc = v && exp_rdy;
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
         end
         m_count = 0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (m_full[k] && r[k]) m_full[k] = 1'b0;
         if (last_acc) begin
            m_full[s] = 1'b1;
            m_data[s] = d;
            m_count++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (rst) m_known = 1'b1;
      if (m_known) check_outputs();
   endtask

   initial begin
      bit         v;
      logic [N-1:0] d;
      logic [1:0] s;
      logic [3:0] r;
      bit         rst;

      m_known  = 1'b0;
      m_count  = 0;
      for (int k = 0; k < 4; k++) begin
         m_full[k] = 1'b0;
         m_data[k] = '0;
      end
      in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0; reset = 1'b1;
      @(negedge clk);

      // Reset then idle, sweeping in_sel.
      step(1'b0, 4'h0, 2'd0, 4'b0000, 1'b1);
      check_eq("rst_valid", {28'd0, out_valid}, 32'd0);
      check_eq("rst_count", {24'd0, accept_count}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'h0, 2'(i), 4'b0000, 1'b0);
         check_eq("idle_rdy", {31'd0, last_rdy}, 32'd1);
      end

      // Single word to channel 2.
      step(1'b1, 4'b1010, 2'd2, 4'b0000, 1'b0);
      check_eq("ch2_valid", {28'd0, out_valid}, 32'h4);
      check_eq("ch2_data", {28'd0, out_data[2*N +: N]}, 32'hA);
      check_eq("ch2_count", {24'd0, accept_count}, 32'd1);

      // Channel 2 full and stalled blocks sel 2 only.
      step(1'b1, 4'b0101, 2'd2, 4'b0000, 1'b0);
      check_eq("ch2_block", {31'd0, last_rdy}, 32'd0);
      check_eq("ch2_hold", {28'd0, out_data[2*N +: N]}, 32'hA);
      step(1'b1, 4'b0101, 2'd0, 4'b0000, 1'b0);
      check_eq("ch0_valid", {28'd0, out_valid}, 32'h5);

      // Simultaneous drain and refill on channel 1.
      step(1'b1, 4'b0001, 2'd1, 4'b0000, 1'b0);
      step(1'b1, 4'b1111, 2'd1, 4'b0010, 1'b0);
      check_eq("ch1_pass_rdy", {31'd0, last_rdy}, 32'd1);
      check_eq("ch1_data", {28'd0, out_data[1*N +: N]}, 32'hF);
      check_eq("ch1_valid", {31'd0, out_valid[1]}, 32'd1);
      check_eq("ch1_count", {24'd0, accept_count}, 32'd4);

      // Back-to-back stream to channel 3, reset on the third word.
      step(1'b1, 4'b0001, 2'd3, 4'b1000, 1'b0);
      check_eq("b2b_d1", {28'd0, out_data[3*N +: N]}, 32'h1);
      step(1'b1, 4'b0010, 2'd3, 4'b1000, 1'b0);
      check_eq("b2b_d2", {28'd0, out_data[3*N +: N]}, 32'h2);
      check_eq("b2b_v2", {31'd0, out_valid[3]}, 32'd1);
      step(1'b1, 4'b0011, 2'd3, 4'b1000, 1'b1);
      check_eq("b2b_rst_v", {28'd0, out_valid}, 32'd0);
      check_eq("b2b_rst_c", {24'd0, accept_count}, 32'd0);
      step(1'b1, 4'b0100, 2'd3, 4'b1000, 1'b0);
      check_eq("b2b_d4", {28'd0, out_data[3*N +: N]}, 32'h4);

      // Counter wrap after 256 accepts.
      step(1'b0, 4'h0, 2'd0, 4'b1111, 1'b1);
      for (int i = 0; i < 255; i++)
         step(1'b1, 4'($urandom), 2'($urandom), 4'b1111, 1'b0);
      check_eq("cnt_255", {24'd0, accept_count}, 32'd255);
      step(1'b1, 4'h9, 2'd1, 4'b1111, 1'b0);
      check_eq("cnt_wrap", {24'd0, accept_count}, 32'd0);

      // Random traffic obeying the hold-until-accepted source rule.
      last_acc = 1'b1;
      v = 1'b0; d = '0; s = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!(v && !last_acc)) begin
            v = ($urandom_range(0, 3) != 0);
            d = 4'($urandom);
            s = 2'($urandom);
         end
         r   = 4'($urandom);
         rst = ($urandom_range(0, 63) == 0);
         step(v, d, s, r, rst);
         if (rst) last_acc = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/demux_1to4_buffered.md
Name: demux_1to4_buffered

Overview:
- Registered 1-to-4 demultiplexer: the distributing counterpart of the Mux2To1 selector.
- Steers one N-bit source word to one of four destination channels, chosen by a 2-bit select.
- Each channel has a one-entry holding register and a valid/ready handshake.
- Used in the datapath wherever a single producer (e.g. ALU result or writeback bus) feeds several consumers that may stall independently.

Parameters:
- N, 4, data width of input word and of each output channel
- CNTW, 8, width of the accepted-transfer counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  source presents a word
- in_ready  output  1  block can accept the presented word this cycle
- in_data  input  N  word to distribute
- in_sel  input  2  destination channel index 0..3
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: consumer k takes the word this cycle
- out_data  output  4*N  channel k word at bits [k*N +: N]
- accept_count  output  CNTW  number of accepted input transfers, wraps

Behaviour:
- Reset (sync, active-high, checked at posedge clk):
  - out_valid = 4'b0000.
  - out_data = all zeros.
  - accept_count = 0.
  - Reset overrides any simultaneous accept or drain.
  - Reset mid-operation discards all held words.
- Per-channel state: full[k] (drives out_valid[k]) and data_q[k] (drives out_data slice k).
- Drain: channel k drains in a cycle when out_valid[k] && out_ready[k].
- in_ready, combinational:
  - in_ready = !full[in_sel] || out_ready[in_sel].
  - Depends only on the selected channel; other channels being full never block.
  - in_ready is meaningful irrespective of in_valid.
- Accept: occurs when in_valid && in_ready.
  - On the next posedge, data_q[in_sel] <= in_data, full[in_sel] <= 1, accept_count += 1 (mod 2^CNTW).
- Latency: word visible on out_data and out_valid one cycle after accept.
  - No combinational path from in_data to out_data.
- Simultaneous accept and drain on the same channel:
  - The old word is consumed and the new word is loaded.
  - full stays 1.
  - Full throughput of one word per cycle per channel.
- Drain without accept: full[k] <= 0 next cycle; data_q[k] retains its last value (don't-care for consumers).
- Accept on channel a with drain on a different channel b: both happen independently in the same cycle.
- Channel full and out_ready low: in_ready = 0 for that select. The source must hold in_valid, in_data and in_sel stable until accepted.
- A word is never overwritten while full unless it drains in the same cycle; no data loss, no duplication.
- in_valid low: no state change except drains.
- in_sel is ignored when in_valid = 0.
- out_ready[k] while out_valid[k] = 0 has no effect.
- accept_count wraps from 2^CNTW-1 to 0 with no flag.

Decomposition:
- Shared package/header:
  - localparam NUM_CH = 4, SEL_W = 2.
  - Channel-index constants CH0..CH3.
- One natural sub-module: demux_slot.
  - One holding register with full flag.
  - Inputs: load, drain, d. Outputs: full, q.
  - Instantiated 4 times under a generate loop.
- Top level contains:
  - The in_sel decoder (one-hot load enables).
  - in_ready selection.
  - accept_count.

Test Plan:
- Reset, then idle cycle -> out_valid = 0000, out_data = 0, accept_count = 0, in_ready = 1 for all in_sel.
- in_data = 4'b1010, in_sel = 2, in_valid for one cycle, out_ready = 0000 -> next cycle out_valid = 0100, channel 2 data = 1010, accept_count = 1.
- Channel 2 full, out_ready = 0000, present 4'b0101 to sel 2 -> in_ready = 0, no state change. Present the same word to sel 0 -> accepted, out_valid = 0101.
- Channel 1 full with 4'b0001, out_ready = 0010, present 4'b1111 to sel 1 -> in_ready = 1; next cycle out_valid[1] = 1, data = 1111, accept_count incremented once.
- Back-to-back words 0001, 0010, 0011, 0100 to sel 3 with out_ready[3] = 1 every cycle -> each appears exactly one cycle after its accept, no bubbles. Assert reset during the third word -> all out_valid = 0 and counter = 0 on the next cycle.
- 256 accepted transfers with CNTW = 8 -> accept_count wraps to 0.
